// File: rtl/arb_pkg.sv
// Shared defaults and index type for the ingress queue and the round-robin arbiter
// that drives its grant vector.
package arb_pkg;
  localparam int NUM_PORTS_DEF = 4;
  localparam int DATA_W_DEF    = 8;
  localparam int DEPTH_DEF     = 2;

  typedef logic [$clog2(NUM_PORTS_DEF)-1:0] port_idx_t;
endpackage

// File: rtl/arb_ingress_queue_if.sv
// Bundle of the ingress push ports, the arbiter request/grant pair and the output stage.
// slave = the queue itself, master = the surrounding environment (requesters, arbiter, sink).
interface arb_ingress_queue_if
  import arb_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int DATA_W    = DATA_W_DEF
);
  localparam int PW = $clog2(NUM_PORTS);

  // Push side: a word moves when in_valid_i[k] && in_ready_o[k] at a rising edge.
  // Output side: a word moves when out_valid_o && out_ready_i at a rising edge.
  logic [NUM_PORTS-1:0]        in_valid_i;
  logic [NUM_PORTS-1:0]        in_ready_o;
  logic [NUM_PORTS*DATA_W-1:0] in_data_i;
  logic [NUM_PORTS-1:0]        arb_req_o;
  logic [NUM_PORTS-1:0]        arb_gnt_i;
  logic                        out_valid_o;
  logic                        out_ready_i;
  logic [DATA_W-1:0]           out_data_o;
  logic [PW-1:0]               out_port_o;
  logic                        err_o;

  modport slave (
    input  in_valid_i, in_data_i, arb_gnt_i, out_ready_i,
    output in_ready_o, arb_req_o, out_valid_o, out_data_o, out_port_o, err_o
  );

  modport master (
    output in_valid_i, in_data_i, arb_gnt_i, out_ready_i,
    input  in_ready_o, arb_req_o, out_valid_o, out_data_o, out_port_o, err_o
  );
endinterface

// File: rtl/arb_port_fifo.sv
// Per-port DEPTH-entry FIFO. Ready comes from registered count only, so a full FIFO
// refuses a push even when it is popped in the same cycle.
module arb_port_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_valid_i,
  output logic              push_ready_o,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              empty_o,
  output logic [DATA_W-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]                  wptr_q, wptr_d;
  logic [AW-1:0]                  rptr_q, rptr_d;
  logic [CW-1:0]                  count_q, count_d;
  logic [DEPTH-1:0][DATA_W-1:0]   mem_q, mem_d;
  logic                           do_push, do_pop;

  always_comb begin
    push_ready_o = (count_q != CW'(DEPTH));
    empty_o      = (count_q == '0);
    head_o       = mem_q[rptr_q];
    do_push      = push_valid_i && push_ready_o;
    do_pop       = pop_i && !empty_o;

    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[wptr_q] = push_data_i;
      wptr_d        = wptr_q + AW'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    // Pointers wrap naturally because DEPTH is a power of two.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/arb_ingress_queue.sv
// Per-port ingress FIFOs feeding one registered output stage; an external round-robin
// arbiter picks the port each cycle, and malformed grants are flagged on a sticky error.
module arb_ingress_queue
  import arb_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  arb_ingress_queue_if.slave bus
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam logic [NUM_PORTS-1:0] ONE = {{(NUM_PORTS-1){1'b0}}, 1'b1};

  logic [NUM_PORTS-1:0]             empty, ready, pop, req;
  logic [NUM_PORTS-1:0][DATA_W-1:0] head;
  logic                             load_ok, gnt_onehot, gnt_covered, gnt_legal;
  logic [PW-1:0]                    gnt_idx;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [PW-1:0]     out_port_q, out_port_d;
  logic              err_q, err_d;

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    arb_port_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk          (clk),
      .reset        (reset),
      .push_valid_i (bus.in_valid_i[k]),
      .push_ready_o (ready[k]),
      .push_data_i  (bus.in_data_i[k*DATA_W +: DATA_W]),
      .pop_i        (pop[k]),
      .empty_o      (empty[k]),
      .head_o       (head[k])
    );
  end

  always_comb begin
    load_ok     = !out_valid_q || bus.out_ready_i;
    req         = ~empty & {NUM_PORTS{load_ok}};
    gnt_onehot  = (bus.arb_gnt_i != '0) && ((bus.arb_gnt_i & (bus.arb_gnt_i - ONE)) == '0);
    gnt_covered = ((bus.arb_gnt_i & ~req) == '0);
    // A grant to a non-requesting port is illegal; this also blocks loads while stalled.
    gnt_legal   = gnt_onehot && gnt_covered;

    gnt_idx = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (bus.arb_gnt_i[k]) gnt_idx = PW'(k);
    end

    pop         = gnt_legal ? bus.arb_gnt_i : '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_port_d  = out_port_q;
    err_d       = err_q || ((bus.arb_gnt_i != '0) && !gnt_legal);
    if (gnt_legal) begin
      out_valid_d = 1'b1;
      out_data_d  = head[gnt_idx];
      out_port_d  = gnt_idx;
    end else if (bus.out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_port_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_port_q  <= out_port_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready_o  = ready;
  assign bus.arb_req_o   = req;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_data_o  = out_data_q;
  assign bus.out_port_o  = out_port_q;
  assign bus.err_o       = err_q;
endmodule

// File: tb/tb_arb_ingress_queue.sv
// Directed bench for arb_ingress_queue: the bench plays requesters, arbiter and sink,
// keeps per-port model queues and an expected-output scoreboard.
module tb_arb_ingress_queue;
  localparam int NP    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 2;
  localparam int PW    = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  arb_ingress_queue_if #(.NUM_PORTS(NP), .DATA_W(DW)) bus ();

  arb_ingress_queue #(
    .NUM_PORTS (NP),
    .DATA_W    (DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [PW+DW-1:0] exp_q[$];
  logic [DW-1:0]    mq[NP][$];
  logic             model_ov  = 1'b0;
  logic             model_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready_o),  32'hF);
    check({tag, "_arb_req"},   32'(bus.arb_req_o),   32'h0);
    check({tag, "_out_valid"}, 32'(bus.out_valid_o), 32'h0);
    check({tag, "_out_data"},  32'(bus.out_data_o),  32'h0);
    check({tag, "_out_port"},  32'(bus.out_port_o),  32'h0);
    check({tag, "_err"},       32'(bus.err_o),       32'h0);
  endtask

  // One clock cycle: drive inputs, check combinational outputs against the model,
  // advance the model, take the edge, then check registered outputs.
  task automatic cycle(input logic [NP-1:0] vld, input logic [NP*DW-1:0] data,
                       input logic [NP-1:0] gnt, input logic rdy);
    logic          load_ok;
    logic          legal;
    logic [NP-1:0] mreq;
    logic [NP-1:0] acc;
    int            ones;
    bus.in_valid_i  = vld;
    bus.in_data_i   = data;
    bus.arb_gnt_i   = gnt;
    bus.out_ready_i = rdy;
    #1;
    load_ok = !model_ov || rdy;
    ones    = 0;
    for (int k = 0; k < NP; k++) begin
      mreq[k] = (mq[k].size() != 0) && load_ok;
      acc[k]  = (mq[k].size() < DEPTH);
      if (gnt[k]) ones++;
    end
    check("arb_req", 32'(bus.arb_req_o), 32'(mreq));
    check("in_ready", 32'(bus.in_ready_o), 32'(acc));

    if (model_ov && rdy) void'(exp_q.pop_front());
    legal = (ones == 1) && ((gnt & ~mreq) == '0);
    if (legal) begin
      for (int k = 0; k < NP; k++) begin
        if (gnt[k]) exp_q.push_back({k[PW-1:0], mq[k].pop_front()});
      end
      model_ov = 1'b1;
    end else begin
      if (gnt != '0) model_err = 1'b1;
      if (rdy) model_ov = 1'b0;
    end
    for (int k = 0; k < NP; k++) begin
      if (vld[k] && acc[k]) mq[k].push_back(data[k*DW +: DW]);
    end

    @(posedge clk);
    #1;
    check("out_valid", 32'(bus.out_valid_o), 32'(model_ov));
    check("err", 32'(bus.err_o), 32'(model_err));
    if (model_ov && exp_q.size() != 0) begin
      check("out_data", 32'(bus.out_data_o), 32'(exp_q[0][DW-1:0]));
      check("out_port", 32'(bus.out_port_o), 32'(exp_q[0][DW +: PW]));
    end
  endtask

  initial begin
    bus.in_valid_i  = '0;
    bus.in_data_i   = '0;
    bus.arb_gnt_i   = '0;
    bus.out_ready_i = 1'b0;

    // Reset values while reset is held low.
    repeat (2) @(posedge clk);
    #1;
    check_reset_outs("rst");
    reset = 1'b1;

    // Single push on port 2: request next cycle, output one cycle after the grant.
    cycle(4'b0100, {8'h00, 8'hA1, 8'h00, 8'h00}, 4'b0000, 1'b1);
    check("a1_req", 32'(bus.arb_req_o), 32'h4);
    cycle(4'b0000, '0, 4'b0100, 1'b1);
    check("a1_data", 32'(bus.out_data_o), 32'hA1);
    check("a1_port", 32'(bus.out_port_o), 32'h2);
    cycle(4'b0000, '0, 4'b0000, 1'b1);

    // Three pushes to port 0 with no grants: third is refused.
    cycle(4'b0001, {24'h0, 8'h51}, 4'b0000, 1'b1);
    cycle(4'b0001, {24'h0, 8'h52}, 4'b0000, 1'b1);
    cycle(4'b0001, {24'h0, 8'h53}, 4'b0000, 1'b1);
    check("full_ready0", 32'(bus.in_ready_o[0]), 32'h0);
    cycle(4'b0000, '0, 4'b0001, 1'b1);
    cycle(4'b0000, '0, 4'b0001, 1'b1);
    cycle(4'b0000, '0, 4'b0000, 1'b1);

    // All four ports loaded, rotating grants, one output per cycle.
    cycle(4'b1111, {8'h40, 8'h30, 8'h20, 8'h10}, 4'b0000, 1'b1);
    cycle(4'b0000, '0, 4'b0001, 1'b1);
    cycle(4'b0000, '0, 4'b0010, 1'b1);
    cycle(4'b0000, '0, 4'b0100, 1'b1);
    cycle(4'b0000, '0, 4'b1000, 1'b1);
    cycle(4'b0000, '0, 4'b0000, 1'b1);

    // Output stall for 3 cycles: no requests, output stable.
    cycle(4'b0010, {16'h0, 8'h61, 8'h00}, 4'b0000, 1'b1);
    cycle(4'b0010, {16'h0, 8'h62, 8'h00}, 4'b0000, 1'b1);
    cycle(4'b0000, '0, 4'b0010, 1'b1);
    repeat (3) cycle(4'b0000, '0, 4'b0000, 1'b0);
    check("stall_data", 32'(bus.out_data_o), 32'h61);
    cycle(4'b0000, '0, 4'b0000, 1'b1);
    cycle(4'b0000, '0, 4'b0010, 1'b1);
    cycle(4'b0000, '0, 4'b0000, 1'b1);

    // Two-hot grant: no pop, sticky error.
    cycle(4'b0011, {16'h0, 8'h72, 8'h71}, 4'b0000, 1'b1);
    cycle(4'b0000, '0, 4'b0011, 1'b1);
    check("bad_gnt_err", 32'(bus.err_o), 32'h1);
    check("bad_gnt_novalid", 32'(bus.out_valid_o), 32'h0);
    cycle(4'b0000, '0, 4'b0000, 1'b1);
    check("err_sticky", 32'(bus.err_o), 32'h1);
    cycle(4'b0000, '0, 4'b0001, 1'b1);
    cycle(4'b0000, '0, 4'b0010, 1'b1);
    cycle(4'b0000, '0, 4'b0000, 1'b1);

    // Reset mid-operation with two buffered entries and a valid output.
    cycle(4'b1000, {8'h81, 24'h0}, 4'b0000, 1'b1);
    cycle(4'b1000, {8'h82, 24'h0}, 4'b0000, 1'b1);
    cycle(4'b0000, '0, 4'b1000, 1'b0);
    cycle(4'b1000, {8'h83, 24'h0}, 4'b0000, 1'b0);
    check("pre_rst_valid", 32'(bus.out_valid_o), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outs("mid_rst");
    for (int k = 0; k < NP; k++) mq[k].delete();
    exp_q.delete();
    model_ov  = 1'b0;
    model_err = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    cycle(4'b0000, '0, 4'b0000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
